axi_slv_mem: RTL and testbench
==============================

Name: axi_slv_mem

Overview:
- AXI3 slave memory responder; the counterpart of the team's AXI master read/write engines.
- Accepts write and read INCR bursts, stores data in an internal register-array memory and returns write and read responses.
- Used as the DDR stand-in in bandwidth-test benches and as a small on-fabric scratch memory.
- Read and write paths are independent and may be active at the same time.

Parameters:
ID_WIDTH, 6, width of all AXI ID fields
DATA_WIDTH, 64, data bus width in bits (32, 64 or 128)
B_BURST_LENGTH, 4, width of awlen/arlen (AXI3)
MEM_AW, 10, log2 of memory depth in DATA_WIDTH words (default 1024 words)

Ports:
clk  in  1  single clock
rst  in  1  synchronous, active-high reset
s_axi_awid  in  ID_WIDTH  write burst ID
s_axi_awaddr  in  32  write byte address
s_axi_awlen  in  B_BURST_LENGTH  beats minus 1
s_axi_awsize  in  3  bytes per beat, log2
s_axi_awburst  in  2  burst type
s_axi_awvalid/s_axi_awready  in/out  1  AW handshake
s_axi_wid  in  ID_WIDTH  ignored (AXI3 compatibility)
s_axi_wdata  in  DATA_WIDTH  write data
s_axi_wstrb  in  DATA_WIDTH/8  byte enables
s_axi_wlast  in  1  last write beat
s_axi_wvalid/s_axi_wready  in/out  1  W handshake
s_axi_bid  out  ID_WIDTH  response ID (= captured awid)
s_axi_bresp  out  2  OKAY=00, SLVERR=10
s_axi_bvalid/s_axi_bready  out/in  1  B handshake
s_axi_arid, araddr, arlen, arsize, arburst  in  as aw*  read address channel
s_axi_arvalid/s_axi_arready  in/out  1  AR handshake
s_axi_rid  out  ID_WIDTH  = captured arid
s_axi_rdata  out  DATA_WIDTH  read data
s_axi_rresp  out  2  per-beat response
s_axi_rlast  out  1  last read beat
s_axi_rvalid/s_axi_rready  out/in  1  R handshake
wr_burst_cnt  out  32  completed write bursts (B handshakes)
rd_burst_cnt  out  32  completed read bursts (rlast handshakes)
err_cnt  out  32  bursts answered with SLVERR

Behaviour:
- Reset: all valid outputs 0. awready=1 and arready=1 (idle). All counters 0. ID, resp, rdata and rlast are 0. Memory contents are not reset.
- Word index = addr[ADDR_LSB +: MEM_AW], where ADDR_LSB = log2(DATA_WIDTH/8). Higher bits are ignored, so the address wraps modulo depth. Pointer increments by 1 per beat and wraps from 2^MEM_AW-1 to 0.
- A burst is legal when burst==01 (INCR) and size==ADDR_LSB. Otherwise all beats are still transferred with no memory write, and the response is SLVERR.
- Write FSM, W_IDLE -> W_DATA -> W_RESP:
  - W_IDLE: awready=1. AW handshake captures id, pointer, len and legal flag, clears the beat counter and moves to W_DATA. awready drops the next cycle.
  - W_DATA: wready=1. Each W handshake writes strobed bytes to mem[ptr] if legal, then increments ptr and count.
  - The beat where count==len ends the burst and moves to W_RESP.
  - If wlast mismatches (wlast on count!=len, or no wlast on count==len), a sticky flag forces SLVERR for that burst.
  - W_RESP: bvalid=1 until bready. The handshake increments wr_burst_cnt (and err_cnt if SLVERR) and returns to W_IDLE. One outstanding write only.
- Read FSM, R_IDLE -> R_DATA:
  - R_IDLE: arready=1. AR handshake captures burst state.
  - R_DATA: rvalid=1 starting the cycle after the AR handshake. rdata = mem[ptr] (combinational array read, registered output not required). rlast=(count==len). rresp=OKAY if legal, else SLVERR with rdata=0.
  - rdata/rresp/rlast are held stable while rvalid && !rready.
  - The handshake with rlast increments rd_burst_cnt (and err_cnt if SLVERR) and returns to R_IDLE. One outstanding read only.
- Read-during-write on the same word in the same cycle returns pre-write data; the write takes effect at that clock edge.
- If both FSMs bump err_cnt in the same cycle, it increments by 2. Counters wrap at 2^32.
- rst asserted mid-burst returns both FSMs to idle next cycle. Valids drop and the partial burst is abandoned. Memory keeps bytes already written.

Decomposition:
- Package axi_slv_pkg: resp constants (OKAY, SLVERR), burst constants (FIXED, INCR, WRAP), and the write/read state enums.
- One sub-module, axi_slv_mem_ram: byte-enabled register-array memory with one write port and one combinational read port.

Test Plan:
- Write INCR awaddr=0x100, awlen=3, data 0x11..0x44, wstrb=0xFF -> bresp=00, bid=awid. Then read the same address -> 4 beats 0x11..0x44, rlast on beat 4, wr_burst_cnt=1, rd_burst_cnt=1.
- Write one beat at 0x0 with wstrb=0x0F, data 0xAAAAAAAA_BBBBBBBB over old 0 -> a readback returns 0x00000000_BBBBBBBB.
- awburst=00 (FIXED) at 0x200, len=1 -> both W beats accepted, bresp=10, memory unchanged, err_cnt=1.
- wlast asserted on beat 2 of awlen=3 -> burst still runs 4 beats, bresp=10.
- Read rready toggled 1-0-0-1 during a 4-beat read -> rdata is held for stalled cycles and no beat is lost. A concurrent write burst completes independently.
- Write from awaddr=0x1FF8, awlen=1 (word 1023, then wraps) -> data lands in word 1023 then word 0. Assert rst mid-read -> rvalid=0 next cycle and arready=1.

Source files
------------

// File: rtl/axi_slv_pkg.sv
// Shared constants and FSM state types for the AXI3 slave memory.
package axi_slv_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } w_state_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } r_state_e;

endpackage

// File: rtl/axi_slv_mem_if.sv
// AXI3 write/read channel bundle; slave modport faces the memory.
interface axi_slv_mem_if #(
  parameter int ID_WIDTH       = 6,
  parameter int DATA_WIDTH     = 64,
  parameter int B_BURST_LENGTH = 4
);
  logic [ID_WIDTH-1:0]       awid;
  logic [31:0]               awaddr;
  logic [B_BURST_LENGTH-1:0] awlen;
  logic [2:0]                awsize;
  logic [1:0]                awburst;
  logic                      awvalid;
  logic                      awready;

  logic [ID_WIDTH-1:0]       wid;
  logic [DATA_WIDTH-1:0]     wdata;
  logic [DATA_WIDTH/8-1:0]   wstrb;
  logic                      wlast;
  logic                      wvalid;
  logic                      wready;

  logic [ID_WIDTH-1:0]       bid;
  logic [1:0]                bresp;
  logic                      bvalid;
  logic                      bready;

  logic [ID_WIDTH-1:0]       arid;
  logic [31:0]               araddr;
  logic [B_BURST_LENGTH-1:0] arlen;
  logic [2:0]                arsize;
  logic [1:0]                arburst;
  logic                      arvalid;
  logic                      arready;

  logic [ID_WIDTH-1:0]       rid;
  logic [DATA_WIDTH-1:0]     rdata;
  logic [1:0]                rresp;
  logic                      rlast;
  logic                      rvalid;
  logic                      rready;

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
    input  wid, wdata, wstrb, wlast, wvalid,              output wready,
    output bid, bresp, bvalid,                            input  bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid, output arready,
    output rid, rdata, rresp, rlast, rvalid,              input  rready
  );

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid, input  awready,
    output wid, wdata, wstrb, wlast, wvalid,              input  wready,
    input  bid, bresp, bvalid,                            output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid, input  arready,
    input  rid, rdata, rresp, rlast, rvalid,              output rready
  );

endinterface

// File: rtl/axi_slv_mem_ram.sv
// Byte-enabled register-array memory: one write port, one combinational read port.
module axi_slv_mem_ram #(
  parameter int DATA_WIDTH = 64,
  parameter int MEM_AW     = 10
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [MEM_AW-1:0]       waddr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic [MEM_AW-1:0]       raddr,
  output logic [DATA_WIDTH-1:0]   rdata
);

  logic [DATA_WIDTH-1:0] mem [2**MEM_AW];

  // Strobed byte writes; the array holds its contents across reset.
  // NOTE: storage arrays get no reset branch -- clearing them would force a per-bit reset net and is not wanted here.
  always_ff @(posedge clk) begin
    for (int b = 0; b < DATA_WIDTH/8; b++) begin
      if (we && wstrb[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
    end
  end

  // Same-cycle read of a word being written sees the old value.
  assign rdata = mem[raddr];

endmodule

// File: rtl/axi_slv_mem.sv
// AXI3 slave memory responder with independent write and read burst engines.
module axi_slv_mem
  import axi_slv_pkg::*;
#(
  parameter int ID_WIDTH       = 6,
  parameter int DATA_WIDTH     = 64,
  parameter int B_BURST_LENGTH = 4,
  parameter int MEM_AW         = 10
) (
  input  logic         clk,
  input  logic         rst,
  axi_slv_mem_if.slave s_axi,
  output logic [31:0]  wr_burst_cnt,
  output logic [31:0]  rd_burst_cnt,
  output logic [31:0]  err_cnt
);

  localparam int         ADDR_LSB  = $clog2(DATA_WIDTH/8);
  localparam logic [2:0] BEAT_SIZE = 3'(ADDR_LSB);

  w_state_e                  w_state, w_next;
  logic [ID_WIDTH-1:0]       w_id;
  logic [MEM_AW-1:0]         w_ptr;
  logic [B_BURST_LENGTH-1:0] w_len, w_cnt;
  logic                      w_legal, w_err;

  r_state_e                  r_state, r_next;
  logic [ID_WIDTH-1:0]       r_id;
  logic [MEM_AW-1:0]         r_ptr;
  logic [B_BURST_LENGTH-1:0] r_len, r_cnt;
  logic                      r_legal;

  logic                      aw_hs, w_hs, b_hs, ar_hs, r_hs, r_done;
  logic                      w_last_beat, b_err, r_err;
  logic [DATA_WIDTH-1:0]     ram_rdata;
  logic                      unused_bits;

  assign aw_hs       = s_axi.awvalid && s_axi.awready;
  assign w_hs        = s_axi.wvalid && s_axi.wready;
  assign b_hs        = s_axi.bvalid && s_axi.bready;
  assign ar_hs       = s_axi.arvalid && s_axi.arready;
  assign r_hs        = s_axi.rvalid && s_axi.rready;
  assign r_done      = r_hs && s_axi.rlast;
  assign w_last_beat = (w_cnt == w_len);
  assign b_err       = b_hs && (s_axi.bresp == RESP_SLVERR);
  assign r_err       = r_done && (s_axi.rresp == RESP_SLVERR);

  // State registers for both engines.
  // NOTE: clocked state uses <= so every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
    end
  end

  // Write engine next state and channel ready/valid.
  // NOTE: every output gets a default before the case so no path leaves a latch behind.
  always_comb begin
    w_next        = w_state;
    s_axi.awready = 1'b0;
    s_axi.wready  = 1'b0;
    s_axi.bvalid  = 1'b0;
    unique case (w_state)
      W_IDLE: begin
        s_axi.awready = 1'b1;
        if (s_axi.awvalid) w_next = W_DATA;
      end
      W_DATA: begin
        s_axi.wready = 1'b1;
        if (s_axi.wvalid && w_last_beat) w_next = W_RESP;
      end
      W_RESP: begin
        s_axi.bvalid = 1'b1;
        if (s_axi.bready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  // Write burst context: capture on AW, advance per beat, latch framing errors.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_id    <= '0;
      w_ptr   <= '0;
      w_len   <= '0;
      w_cnt   <= '0;
      w_legal <= 1'b1;
      w_err   <= 1'b0;
    end else if (aw_hs) begin
      w_id    <= s_axi.awid;
      w_ptr   <= s_axi.awaddr[ADDR_LSB +: MEM_AW];
      w_len   <= s_axi.awlen;
      w_cnt   <= '0;
      w_legal <= (s_axi.awburst == BURST_INCR) && (s_axi.awsize == BEAT_SIZE);
      w_err   <= 1'b0;
    end else if (w_hs) begin
      w_ptr <= w_ptr + MEM_AW'(1);
      w_cnt <= w_cnt + B_BURST_LENGTH'(1);
      if (s_axi.wlast != w_last_beat) w_err <= 1'b1;
    end
  end

  assign s_axi.bid   = w_id;
  assign s_axi.bresp = (s_axi.bvalid && (!w_legal || w_err)) ? RESP_SLVERR : RESP_OKAY;

  // Read engine next state and channel ready/valid.
  always_comb begin
    r_next        = r_state;
    s_axi.arready = 1'b0;
    s_axi.rvalid  = 1'b0;
    unique case (r_state)
      R_IDLE: begin
        s_axi.arready = 1'b1;
        if (s_axi.arvalid) r_next = R_DATA;
      end
      R_DATA: begin
        s_axi.rvalid = 1'b1;
        if (s_axi.rready && (r_cnt == r_len)) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  // Read burst context: capture on AR, advance only on accepted beats so stalls hold the beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_id    <= '0;
      r_ptr   <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_legal <= 1'b1;
    end else if (ar_hs) begin
      r_id    <= s_axi.arid;
      r_ptr   <= s_axi.araddr[ADDR_LSB +: MEM_AW];
      r_len   <= s_axi.arlen;
      r_cnt   <= '0;
      r_legal <= (s_axi.arburst == BURST_INCR) && (s_axi.arsize == BEAT_SIZE);
    end else if (r_hs) begin
      r_ptr <= r_ptr + MEM_AW'(1);
      r_cnt <= r_cnt + B_BURST_LENGTH'(1);
    end
  end

  assign s_axi.rid   = r_id;
  assign s_axi.rdata = (s_axi.rvalid && r_legal) ? ram_rdata : '0;
  assign s_axi.rresp = (s_axi.rvalid && !r_legal) ? RESP_SLVERR : RESP_OKAY;
  assign s_axi.rlast = s_axi.rvalid && (r_cnt == r_len);

  // Completed-burst and error counters; both engines may add an error in one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_burst_cnt <= '0;
      rd_burst_cnt <= '0;
      err_cnt      <= '0;
    end else begin
      if (b_hs)   wr_burst_cnt <= wr_burst_cnt + 32'd1;
      if (r_done) rd_burst_cnt <= rd_burst_cnt + 32'd1;
      err_cnt <= err_cnt + 32'(b_err) + 32'(r_err);
    end
  end

  axi_slv_mem_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_AW     (MEM_AW)
  ) u_ram (
    .clk   (clk),
    .we    (w_hs && w_legal),
    .waddr (w_ptr),
    .wdata (s_axi.wdata),
    .wstrb (s_axi.wstrb),
    .raddr (r_ptr),
    .rdata (ram_rdata)
  );

  // Address bits outside the word index and the AXI3 write ID carry no meaning here.
  assign unused_bits = ^{s_axi.wid,
                         s_axi.awaddr[31:ADDR_LSB+MEM_AW], s_axi.awaddr[ADDR_LSB-1:0],
                         s_axi.araddr[31:ADDR_LSB+MEM_AW], s_axi.araddr[ADDR_LSB-1:0]};

endmodule

// File: tb/tb_axi_slv_mem.sv
// Directed bench for axi_slv_mem with a word-level memory model and a per-cycle compare process.
module tb_axi_slv_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] wr_burst_cnt, rd_burst_cnt, err_cnt;

  axi_slv_mem_if #(.ID_WIDTH(6), .DATA_WIDTH(64), .B_BURST_LENGTH(4)) s_axi ();

  axi_slv_mem #(
    .ID_WIDTH(6), .DATA_WIDTH(64), .B_BURST_LENGTH(4), .MEM_AW(10)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .s_axi        (s_axi),
    .wr_burst_cnt (wr_burst_cnt),
    .rd_burst_cnt (rd_burst_cnt),
    .err_cnt      (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } r_beat_t;

  typedef struct {
    logic [5:0] id;
    logic [1:0] resp;
  } b_rsp_t;

  logic [63:0] mdl [1024];
  r_beat_t     r_exp [$];
  b_rsp_t      b_exp [$];
  int          exp_wr, exp_rd, exp_err;
  logic [63:0] last_rdata;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Write one burst; the model memory is updated as each beat is accepted.
  task automatic wr_burst(input logic [5:0] id, input logic [31:0] addr, input int len,
                          input logic [2:0] size, input logic [1:0] burst,
                          input logic [63:0] pat, input logic [7:0] strb, input int last_at);
    bit          legal;
    bit          bad;
    int          ptr;
    int          n;
    logic [63:0] d;
    legal = (burst == 2'b01) && (size == 3'd3);
    bad   = !legal;
    ptr   = int'(addr[12:3]);
    s_axi.awid = id; s_axi.awaddr = addr; s_axi.awlen = 4'(len);
    s_axi.awsize = size; s_axi.awburst = burst; s_axi.awvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!s_axi.awready && n < 64);
    check("aw_ready", s_axi.awready, 1);
    @(posedge clk); #1;
    s_axi.awvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      d = pat * 64'(i + 1);
      s_axi.wid = id; s_axi.wdata = d; s_axi.wstrb = strb;
      s_axi.wlast = (i == last_at); s_axi.wvalid = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!s_axi.wready && n < 64);
      check("w_ready", s_axi.wready, 1);
      if (legal)
        for (int b = 0; b < 8; b++) if (strb[b]) mdl[ptr][b*8 +: 8] = d[b*8 +: 8];
      if ((i == last_at) != (i == len)) bad = 1'b1;
      ptr = (ptr + 1) % 1024;
      @(posedge clk); #1;
    end
    s_axi.wvalid = 1'b0;
    s_axi.wlast  = 1'b0;
    b_exp.push_back('{id: id, resp: bad ? 2'b10 : 2'b00});
  endtask

  // Issue one read burst; expected beats come from the model at issue time.
  task automatic rd_burst(input logic [5:0] id, input logic [31:0] addr, input int len,
                          input logic [2:0] size, input logic [1:0] burst);
    bit legal;
    int ptr;
    int n;
    legal = (burst == 2'b01) && (size == 3'd3);
    ptr   = int'(addr[12:3]);
    for (int i = 0; i <= len; i++) begin
      r_exp.push_back('{id: id, data: legal ? mdl[ptr] : 64'h0,
                        resp: legal ? 2'b00 : 2'b10, last: (i == len)});
      ptr = (ptr + 1) % 1024;
    end
    s_axi.arid = id; s_axi.araddr = addr; s_axi.arlen = 4'(len);
    s_axi.arsize = size; s_axi.arburst = burst; s_axi.arvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!s_axi.arready && n < 64);
    check("ar_ready", s_axi.arready, 1);
    @(posedge clk); #1;
    s_axi.arvalid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while ((r_exp.size() != 0 || b_exp.size() != 0) && n < 200);
    check("r_queue_drained", 64'(r_exp.size()), 0);
    check("b_queue_drained", 64'(b_exp.size()), 0);
    @(posedge clk); #1;
  endtask

  // Compare process: every cycle the counters and any valid response are checked against the model.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      r_exp.delete();
      b_exp.delete();
      exp_wr = 0; exp_rd = 0; exp_err = 0;
    end else begin
      check("wr_burst_cnt", wr_burst_cnt, 64'(exp_wr));
      check("rd_burst_cnt", rd_burst_cnt, 64'(exp_rd));
      check("err_cnt", err_cnt, 64'(exp_err));
      if (s_axi.rvalid) begin
        if (r_exp.size() == 0) check("r_unexpected", s_axi.rvalid, 0);
        else begin
          check("rdata", s_axi.rdata, r_exp[0].data);
          check("rresp", s_axi.rresp, r_exp[0].resp);
          check("rlast", s_axi.rlast, r_exp[0].last);
          check("rid", s_axi.rid, r_exp[0].id);
          if (s_axi.rready) begin
            last_rdata = s_axi.rdata;
            if (r_exp[0].last) begin
              exp_rd++;
              if (r_exp[0].resp == 2'b10) exp_err++;
            end
            void'(r_exp.pop_front());
          end
        end
      end
      if (s_axi.bvalid) begin
        if (b_exp.size() == 0) check("b_unexpected", s_axi.bvalid, 0);
        else begin
          check("bid", s_axi.bid, b_exp[0].id);
          check("bresp", s_axi.bresp, b_exp[0].resp);
          if (s_axi.bready) begin
            exp_wr++;
            if (b_exp[0].resp == 2'b10) exp_err++;
            void'(b_exp.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  logic [7:0] stall_pat;
  int         n_wait;

  initial begin
    rst = 1'b1;
    s_axi.awid = '0; s_axi.awaddr = '0; s_axi.awlen = '0; s_axi.awsize = '0;
    s_axi.awburst = '0; s_axi.awvalid = 1'b0;
    s_axi.wid = '0; s_axi.wdata = '0; s_axi.wstrb = '0; s_axi.wlast = 1'b0; s_axi.wvalid = 1'b0;
    s_axi.bready = 1'b1;
    s_axi.arid = '0; s_axi.araddr = '0; s_axi.arlen = '0; s_axi.arsize = '0;
    s_axi.arburst = '0; s_axi.arvalid = 1'b0;
    s_axi.rready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state.
    @(negedge clk);
    check("rst_awready", s_axi.awready, 1);
    check("rst_arready", s_axi.arready, 1);
    check("rst_wready", s_axi.wready, 0);
    check("rst_bvalid", s_axi.bvalid, 0);
    check("rst_rvalid", s_axi.rvalid, 0);
    check("rst_rlast", s_axi.rlast, 0);
    check("rst_rdata", s_axi.rdata, 0);
    check("rst_rid", s_axi.rid, 0);
    check("rst_bid", s_axi.bid, 0);
    check("rst_bresp", s_axi.bresp, 0);
    @(posedge clk); #1;

    // Plain INCR write then readback.
    wr_burst(6'd5, 32'h100, 3, 3'd3, 2'b01, 64'h11, 8'hFF, 3);
    wait_idle();
    rd_burst(6'd9, 32'h100, 3, 3'd3, 2'b01);
    wait_idle();
    check("t1_wr_cnt", wr_burst_cnt, 1);
    check("t1_rd_cnt", rd_burst_cnt, 1);
    check("t1_beat4", last_rdata, 64'h44);

    // Partial strobe over a zeroed word.
    wr_burst(6'd1, 32'h0, 0, 3'd3, 2'b01, 64'h0, 8'hFF, 0);
    wr_burst(6'd2, 32'h0, 0, 3'd3, 2'b01, 64'hAAAAAAAA_BBBBBBBB, 8'h0F, 0);
    wait_idle();
    rd_burst(6'd3, 32'h0, 0, 3'd3, 2'b01);
    wait_idle();
    check("t2_strobe", last_rdata, 64'h00000000_BBBBBBBB);

    // FIXED burst is answered SLVERR and leaves memory untouched.
    wr_burst(6'd4, 32'h200, 1, 3'd3, 2'b01, 64'h01010101_01010101, 8'hFF, 1);
    wr_burst(6'd6, 32'h200, 1, 3'd3, 2'b00, 64'hDEADBEEF_00000000, 8'hFF, 1);
    wait_idle();
    check("t3_err_cnt", err_cnt, 1);
    rd_burst(6'd7, 32'h200, 1, 3'd3, 2'b01);
    wait_idle();
    check("t3_unchanged", last_rdata, 64'h02020202_02020202);

    // Early wlast still runs the full burst and yields SLVERR.
    wr_burst(6'd8, 32'h300, 3, 3'd3, 2'b01, 64'h1000, 8'hFF, 1);
    wait_idle();
    check("t4_err_cnt", err_cnt, 2);

    // Read with a non-native beat size returns SLVERR and zero data.
    rd_burst(6'd10, 32'h100, 1, 3'd2, 2'b01);
    wait_idle();
    check("t4_rd_err_cnt", err_cnt, 3);
    check("t4_rd_err_data", last_rdata, 0);

    // Stalled read alongside an independent write burst.
    wr_burst(6'd11, 32'h400, 3, 3'd3, 2'b01, 64'h0F0F0F0F_0F0F0F0F, 8'hFF, 3);
    wait_idle();
    stall_pat = 8'b1111_1001;
    fork
      begin
        rd_burst(6'd12, 32'h400, 3, 3'd3, 2'b01);
        for (int k = 0; k < 8; k++) begin
          s_axi.rready = stall_pat[k];
          @(posedge clk); #1;
        end
        s_axi.rready = 1'b1;
      end
      wr_burst(6'd13, 32'h500, 3, 3'd3, 2'b01, 64'h30303030_30303030, 8'hFF, 3);
    join
    wait_idle();
    check("t5_beat4", last_rdata, 64'h3C3C3C3C_3C3C3C3C);
    rd_burst(6'd14, 32'h500, 3, 3'd3, 2'b01);
    wait_idle();
    check("t5_wr_beat4", last_rdata, 64'hC0C0C0C0_C0C0C0C0);

    // Word 1023 then wrap to word 0.
    wr_burst(6'd15, 32'h1FF8, 1, 3'd3, 2'b01, 64'h77, 8'hFF, 1);
    wait_idle();
    rd_burst(6'd16, 32'h1FF8, 1, 3'd3, 2'b01);
    wait_idle();
    check("t6_wrap_word0", last_rdata, 64'hEE);
    rd_burst(6'd17, 32'h0, 0, 3'd3, 2'b01);
    wait_idle();
    check("t6_word0_direct", last_rdata, 64'hEE);

    // Reset in the middle of a read burst.
    rd_burst(6'd18, 32'h100, 3, 3'd3, 2'b01);
    n_wait = 0;
    do begin @(negedge clk); n_wait++; end while (r_exp.size() > 3 && n_wait < 64);
    check("t7_read_started", s_axi.rvalid, 1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("t7_rvalid", s_axi.rvalid, 0);
    check("t7_arready", s_axi.arready, 1);
    check("t7_rd_cnt", rd_burst_cnt, 0);
    @(posedge clk); #1;
    rd_burst(6'd19, 32'h100, 3, 3'd3, 2'b01);
    wait_idle();
    check("t7_recover_cnt", rd_burst_cnt, 1);
    check("t7_recover_beat4", last_rdata, 64'h44);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
